prod_accum: RTL and testbench
=============================

Name: prod_accum

Overview:
- Downstream consumer of the 64x64 registered multiplier: accumulates a frame of 128-bit unsigned products into one wide sum (dot-product / MAC reduction).
- Host issues `start` with a frame length. The block accepts exactly that many products under valid/ready, then presents the sum under valid/ready.
- The upstream stage aligns `in_valid` with the multiplier's one-cycle output latency.

Parameters:
- PROD_W, 128, product width (fixed by multiplier output).
- ACC_W, 132, accumulator/sum width; must be >= PROD_W.
- LEN_W, 8, width of frame length and product counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset; one clock; reset is asynchronous and active-low.
- start  input  1  begin a frame; sampled only in IDLE.
- frame_len  input  LEN_W  number of products in the frame; latched on an accepted start.
- in_valid  input  1  in_prod is valid.
- in_ready  output  1  block accepts a product this cycle.
- in_prod  input  PROD_W  unsigned product from multiplier.
- out_valid  output  1  out_sum/out_count valid.
- out_ready  input  1  consumer takes the result.
- out_sum  output  ACC_W  accumulated sum.
- out_count  output  LEN_W  number of products accumulated (equals latched frame_len).
- busy  output  1  state != IDLE.
- ovf  output  1  sticky: sum exceeded 2^ACC_W-1 during the current/last frame.

Behaviour:
- Reset (rst low, async): state=IDLE, acc=0, cnt=0, len=0, ovf=0, in_ready=0, out_valid=0, out_sum=0, out_count=0, busy=0. All outputs are registered or decoded from state only. No combinational path from any input to any output.
- IDLE:
  - start=1: latch len=frame_len, clear acc, cnt and ovf.
  - Next state is ACCUM if frame_len!=0, else DONE (sum 0, count 0).
  - start=0: stay in IDLE.
- ACCUM:
  - in_ready=1.
  - Handshake (in_valid & in_ready): acc <= acc + zero-extended in_prod, cnt <= cnt+1.
  - When the accepted product is the last one (cnt==len-1), go to DONE next cycle. acc then includes that product.
  - in_valid=0: hold all state; a bubble costs one cycle.
- DONE:
  - in_ready=0, out_valid=1, out_sum=acc, out_count=cnt.
  - Outputs are stable while out_ready=0.
  - out_ready=1: handshake completes and the state returns to IDLE next cycle.
- Latency: first product accepted one cycle after start. out_valid asserts one cycle after the last product handshake. Minimum frame of N products = N+2 cycles start-to-out_valid-drop with out_ready held high.
- start while not in IDLE is ignored, including in the DONE handshake cycle. There is no back-to-back overlap.
- Arithmetic: unsigned, mod 2^ACC_W by default.
- ovf is set on carry-out of the ACC_W-bit add. It stays set until the next accepted start.
- in_prod while in_ready=0 is ignored.
- Reset mid-frame aborts immediately: partial sum discarded, nothing emitted.
- frame_len=2^LEN_W-1 is legal. cnt never wraps because the frame ends at len.

Optional Feature:
- Macro ACC_SAT_EN.
- Defined: on a carry-out, acc clamps to all-ones (2^ACC_W-1) and stays clamped for the rest of the frame; ovf is still set.
- Undefined: the sum wraps mod 2^ACC_W and ovf flags the wrap.
- Port list is identical in both builds.

Decomposition:
- Package prod_accum_pkg:
  - state enum {IDLE, ACCUM, DONE};
  - PROD_W constant = 128;
  - default ACC_W/LEN_W constants.
- One sub-module prod_accum_add:
  - combinational ACC_W-bit adder of acc + zero-extended product;
  - returns next sum and carry;
  - contains the ACC_SAT_EN clamp.
- The top module holds the FSM, counters and output registers.

Test Plan:
- Reset mid-ACCUM after 2 of 4 products: busy=0, out_valid=0, out_sum=0 immediately. A new start with frame_len=1 and product 7 -> out_sum=7, out_count=1.
- frame_len=3, products 5, 2^64, 2^127 back-to-back, out_ready=1 -> out_valid exactly one cycle after the third handshake; out_sum=2^127+2^64+5; ovf=0.
- frame_len=2, in_valid bubbles between products, out_ready low for 5 cycles -> sum 9 (4+5) held stable all 5 cycles; start pulses during DONE ignored; IDLE after the handshake.
- frame_len=0 -> out_valid with out_sum=0, out_count=0, in_ready never asserted.
- frame_len=17, each product 2^128-1, ACC_W=132:
  - default build: out_sum = 17*(2^128-1) mod 2^132, ovf=1;
  - ACC_SAT_EN build: out_sum = 2^132-1, ovf=1.
- Next start after an overflow frame -> ovf clears to 0. frame_len=1, product 1 -> out_sum=1.

Source files
------------

// File: rtl/prod_accum_pkg.sv
// Shared constants and FSM encoding for the product accumulator.
// Saturating arithmetic is selected with the ACC_SAT_EN macro (see prod_accum_add).
package prod_accum_pkg;

  // Fixed by the upstream 64x64 multiplier.
  localparam int unsigned PROD_W    = 128;
  localparam int unsigned ACC_W_DEF = 132;
  localparam int unsigned LEN_W_DEF = 8;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t ACCUM = 2'd1;
  localparam state_t DONE  = 2'd2;

endpackage

// File: rtl/prod_accum_if.sv
// Host-side bundle for prod_accum: frame start, product stream in, result out, status.
interface prod_accum_if
  import prod_accum_pkg::*;
#(
  parameter int unsigned ACC_W = ACC_W_DEF,
  parameter int unsigned LEN_W = LEN_W_DEF
);

  logic              start;
  logic [LEN_W-1:0]  frame_len;
  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] in_prod;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_sum;
  logic [LEN_W-1:0]  out_count;
  logic              busy;
  logic              ovf;

  modport master (
    output start, frame_len, in_valid, in_prod, out_ready,
    input  in_ready, out_valid, out_sum, out_count, busy, ovf
  );

  modport slave (
    input  start, frame_len, in_valid, in_prod, out_ready,
    output in_ready, out_valid, out_sum, out_count, busy, ovf
  );

endinterface

// File: rtl/prod_accum_add.sv
// Combinational ACC_W-bit accumulate step: acc + zero-extended product, with carry-out.
// With ACC_SAT_EN defined the result clamps to all-ones on carry; otherwise it wraps.
module prod_accum_add
  import prod_accum_pkg::*;
#(
  parameter int unsigned ACC_W = ACC_W_DEF
) (
  input  logic [ACC_W-1:0]  acc_i,
  input  logic [PROD_W-1:0] prod_i,
  output logic [ACC_W-1:0]  sum_o,
  output logic              carry_o
);

  logic [ACC_W:0] raw;

  always_comb begin
    raw     = {1'b0, acc_i} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod_i};
    carry_o = raw[ACC_W];
`ifdef ACC_SAT_EN
    // Once clamped, any further add either carries again or adds zero, so it stays clamped.
    sum_o   = carry_o ? {ACC_W{1'b1}} : raw[ACC_W-1:0];
`else
    sum_o   = raw[ACC_W-1:0];
`endif
  end

endmodule

// File: rtl/prod_accum.sv
// Frame accumulator: sums frame_len unsigned products, then presents the sum under valid/ready.
// Overflow behaviour (wrap vs. clamp) is selected by ACC_SAT_EN inside prod_accum_add.
module prod_accum
  import prod_accum_pkg::*;
#(
  parameter int unsigned ACC_W = ACC_W_DEF,
  parameter int unsigned LEN_W = LEN_W_DEF
) (
  input logic         clk,
  input logic         rst,
  prod_accum_if.slave bus
);

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             ovf_q, ovf_d;

  logic [ACC_W-1:0] add_sum;
  logic             add_carry;

  prod_accum_add #(
    .ACC_W (ACC_W)
  ) u_add (
    .acc_i   (acc_q),
    .prod_i  (bus.in_prod),
    .sum_o   (add_sum),
    .carry_o (add_carry)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          len_d   = bus.frame_len;
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = (bus.frame_len != '0) ? ACCUM : DONE;
        end
      end
      ACCUM: begin
        // in_ready is high for the whole of ACCUM, so in_valid alone is the handshake.
        if (bus.in_valid) begin
          acc_d = add_sum;
          cnt_d = cnt_q + LEN_W'(1);
          ovf_d = ovf_q | add_carry;
          if (cnt_q == len_q - LEN_W'(1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
    end
  end

  // Every output is a register or a decode of the state register.
  assign bus.in_ready  = (state_q == ACCUM);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_sum   = acc_q;
  assign bus.out_count = cnt_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_prod_accum.sv
// Directed bench for prod_accum with an expected-result scoreboard.
module tb_prod_accum;
  import prod_accum_pkg::*;

  localparam int unsigned AW = 132;
  localparam int unsigned LW = 8;

  typedef struct packed {
    logic [AW-1:0] sum;
    logic [LW-1:0] count;
    logic          ovf;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  prod_accum_if #(.ACC_W(AW), .LEN_W(LW)) bus ();

  prod_accum #(
    .ACC_W (AW),
    .LEN_W (LW)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic start_frame(input logic [LW-1:0] len);
    bus.start     = 1'b1;
    bus.frame_len = len;
    step();
    bus.start     = 1'b0;
  endtask

  task automatic push_prod(input logic [PROD_W-1:0] p);
    chk("in_ready", bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.in_prod  = p;
    step();
    bus.in_valid = 1'b0;
    bus.in_prod  = '0;
  endtask

  // Wait for a result, hold out_ready low for `hold` cycles, then handshake.
  task automatic collect(input int hold, input bit poke);
    exp_t e;
    int   n = 0;
    while (bus.out_valid !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk("out_valid_wait", bus.out_valid, 1);
    chk("sb_nonempty", sb.size() != 0, 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      for (int i = 0; i <= hold; i++) begin
        chk("out_sum", bus.out_sum, e.sum);
        chk("out_count", bus.out_count, e.count);
        chk("ovf", bus.ovf, e.ovf);
        chk("out_valid_hold", bus.out_valid, 1);
        chk("in_ready_done", bus.in_ready, 0);
        if (poke) begin
          bus.start     = 1'b1;
          bus.frame_len = 8'd3;
        end
        bus.out_ready = (i == hold);
        step();
      end
      bus.start     = 1'b0;
      bus.out_ready = 1'b0;
      chk("idle_after", bus.busy, 0);
      chk("out_valid_drop", bus.out_valid, 0);
    end
  endtask

  initial begin
    logic [139:0]  wide;
    logic [AW-1:0] model;
    exp_t          e;

    bus.start     = 1'b0;
    bus.frame_len = '0;
    bus.in_valid  = 1'b0;
    bus.in_prod   = '0;
    bus.out_ready = 1'b0;

    #2;
    chk("rst_busy", bus.busy, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_sum", bus.out_sum, 0);
    chk("rst_out_count", bus.out_count, 0);
    chk("rst_ovf", bus.ovf, 0);
    step();
    rst = 1'b1;
    step();

    // Abort mid-frame with an async reset.
    start_frame(8'd4);
    push_prod(128'd11);
    push_prod(128'd13);
    chk("mid_busy", bus.busy, 1);
    rst = 1'b0;
    #1;
    chk("abort_busy", bus.busy, 0);
    chk("abort_out_valid", bus.out_valid, 0);
    chk("abort_out_sum", bus.out_sum, 0);
    chk("abort_in_ready", bus.in_ready, 0);
    step();
    rst = 1'b1;
    step();
    start_frame(8'd1);
    sb.push_back('{sum: AW'(7), count: 8'd1, ovf: 1'b0});
    push_prod(128'd7);
    collect(0, 1'b0);

    // Back-to-back, exact output latency.
    start_frame(8'd3);
    sb.push_back('{sum: (AW'(1) << 127) + (AW'(1) << 64) + AW'(5), count: 8'd3, ovf: 1'b0});
    push_prod(128'd5);
    push_prod(128'd1 << 64);
    chk("out_valid_early", bus.out_valid, 0);
    push_prod(128'd1 << 127);
    chk("out_valid_lat", bus.out_valid, 1);
    collect(0, 1'b0);

    // Bubbles, back-pressure and ignored start pulses in DONE.
    start_frame(8'd2);
    sb.push_back('{sum: AW'(9), count: 8'd2, ovf: 1'b0});
    push_prod(128'd4);
    step();
    step();
    chk("bubble_in_ready", bus.in_ready, 1);
    chk("bubble_sum", bus.out_sum, 4);
    push_prod(128'd5);
    collect(5, 1'b1);

    // Empty frame.
    start_frame(8'd0);
    chk("empty_in_ready", bus.in_ready, 0);
    sb.push_back('{sum: '0, count: 8'd0, ovf: 1'b0});
    collect(0, 1'b0);

    // Overflow: 17 maximal products into a 132-bit accumulator.
    wide = 140'd17 * 140'({128{1'b1}});
`ifdef ACC_SAT_EN
    e = '{sum: {AW{1'b1}}, count: 8'd17, ovf: 1'b1};
`else
    e = '{sum: wide[AW-1:0], count: 8'd17, ovf: 1'b1};
`endif
    sb.push_back(e);
    start_frame(8'd17);
    for (int i = 0; i < 17; i++) push_prod({128{1'b1}});
    collect(1, 1'b0);

    // ovf clears on the next accepted start.
    start_frame(8'd1);
    chk("ovf_cleared", bus.ovf, 0);
    sb.push_back('{sum: AW'(1), count: 8'd1, ovf: 1'b0});
    push_prod(128'd1);
    collect(0, 1'b0);

    // Longest legal frame: products 0..254.
    model = '0;
    for (int i = 0; i < 255; i++) model = model + AW'(i);
    sb.push_back('{sum: model, count: 8'd255, ovf: 1'b0});
    start_frame(8'd255);
    for (int i = 0; i < 255; i++) push_prod(128'(i));
    collect(0, 1'b0);

    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
